nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Sequencer for the 62-20-10 fixed-point MLP. It takes the static flattened weight and bias buses produced by the parameter loader and a 62-byte input vector. It time-multiplexes one bank of 10 signed MACs through three phases: hidden group 1 (neurons 0-9), hidden group 2 (neurons 10-19), then the output layer. A sequential argmax over the 10 logits produces the classification.

## Interface
- FRAC, 4: fractional bits. Biases are pre-shifted left by FRAC; activations are shifted right by FRAC.
- ACC_W, 24: accumulator and logit width, signed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin inference; sampled only in IDLE
- x_flat  in  496  input vector; byte j = x[j], signed 8-bit, j = 0..61
- weight_first_h  in  4960  hidden group 1 weights; byte n*62+j = w[n][j]
- weight_second_h  in  4960  hidden group 2 weights; same layout, neurons 10-19
- bias_first_h  in  80  byte n = bias of hidden neuron n
- bias_second_h  in  80  byte n = bias of hidden neuron 10+n
- weight_out  in  1600  byte n*20+k = weight from hidden k to output n
- bias_out  in  80  byte n = bias of output n
- busy  out  1  inference in progress
- done  out  1  one-cycle pulse when class_out/max_logit update
- class_out  out  4  argmax index, 0..9
- max_logit  out  ACC_W  winning logit, signed

One clock; reset is asynchronous and active-low (ports clk, rst_n).

## Operation
- States: IDLE, H1_MAC, H1_ACT, H2_MAC, H2_ACT, OUT_MAC, ARGMAX, DONE.
- IDLE, start=1:
  - capture x_flat into an internal register;
  - acc[n] <= sext(bias_first_h byte n) << FRAC;
  - j <= 0; go to H1_MAC.
- H1_MAC / H2_MAC:
  - each cycle, for all n: acc[n] += x[j]*w[n][j]. Products are signed 16-bit, sign-extended to ACC_W.
  - j runs 0..61; at j=61 go to the matching ACT state.
- H1_ACT / H2_ACT:
  - h[n or 10+n] <= sat(relu(acc[n]) >>> FRAC), saturated to 0..127 and stored as 8-bit.
  - Reload acc from the next bias bus (bias_second_h, then bias_out), each << FRAC.
  - j <= 0; next state is H2_MAC or OUT_MAC respectively.
- OUT_MAC:
  - acc[n] += h[k]*wo[n][k], k = 0..19. The hidden values feeding this phase are those written in both ACT states.
  - At k=19 go to ARGMAX with best_idx=0 and best=acc[0].
- ARGMAX:
  - 10 cycles, i = 0..9. Replace best when acc[i] > best (signed, strict), so ties go to the lowest index.
  - The i=0 step compares acc[0] against itself.
  - After i=9 go to DONE.
- DONE: class_out <= best_idx, max_logit <= best, done=1; next state is IDLE.
- busy=1 in every state except IDLE. start while busy is ignored and not queued.
- Weight and bias buses must be static while busy; the block does not capture them.
- No overflow detection. Accumulators wrap modulo 2^ACC_W; the defaults cannot overflow (|sum| < 2^21).
- Reset (any time, including mid-inference): state=IDLE, busy=0, done=0, class_out=0, max_logit=0, acc/h/x cleared. Outputs clear asynchronously.

## Timing
- Let E0 be the rising edge that samples start=1 in IDLE; Ek is the k-th edge after it.
- E0->H1_MAC, E62->H1_ACT, E63->H2_MAC, E125->H2_ACT, E126->OUT_MAC, E146->ARGMAX, E156->DONE, E157->IDLE.
- busy is high from E0 to E157; done is high from E156 to E157.
- class_out/max_logit change only at E156 and hold until the next DONE or reset.
- start=1 sampled at E157 (back-to-back) is accepted; that edge becomes the new E0.

## Test plan
- Zero weights, zero biases except bias_out[3]=5 -> done at E156 only; class_out=3, max_logit=80.
- All stimulus bytes below are hex.
  - x all 01, weight_first_h all 01, weight_second_h all 00, all biases 00, weight_out row 7 all 01, others 00.
  - Expected: h[0..9]=3, h[10..19]=0; class_out=7, max_logit=30.
- Saturation/ReLU: x all 7F.
  - weight_first_h all 7F -> h[0..9]=127.
  - weight_second_h all 81 -> h[10..19]=0.
  - weight_out row 2 all 01, others 00 -> class_out=2, max_logit=1270.
- Tie: zero weights, bias_out all 02 -> class_out=0, max_logit=32. Negative case: bias_out all FE except byte 9 = FF -> class_out=9, max_logit=-16.
- Pulse start at E10, E80 and E156 -> all ignored. done is high for exactly one cycle; busy drops at E157; a start at E157 is accepted.
- Assert rst_n=0 at E80 (mid H2_MAC) -> busy, done, class_out and max_logit are 0 immediately, without waiting for a clock edge. After release, a new start completes with done at its own E156 and correct results.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexed sequencer for a 62-20-10 fixed-point MLP: one bank of 10
// signed MACs runs hidden group 1, hidden group 2, the output layer, then argmax.
module nn_layer_sequencer #(
    parameter int FRAC  = 4,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [495:0]            x_flat,
    input  logic [4959:0]           weight_first_h,
    input  logic [4959:0]           weight_second_h,
    input  logic [79:0]             bias_first_h,
    input  logic [79:0]             bias_second_h,
    input  logic [1599:0]           weight_out,
    input  logic [79:0]             bias_out,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              class_out,
    output logic signed [ACC_W-1:0] max_logit
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H1_MAC  = 3'd1,
        S_H1_ACT  = 3'd2,
        S_H2_MAC  = 3'd3,
        S_H2_ACT  = 3'd4,
        S_OUT_MAC = 3'd5,
        S_ARGMAX  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [5:0]              r_j;
    logic signed [7:0]       r_x   [0:61];
    logic [7:0]              r_h   [0:19];
    logic signed [ACC_W-1:0] r_acc [0:9];
    logic signed [ACC_W-1:0] r_best;
    logic [3:0]              r_best_idx;
    logic                    r_busy;
    logic                    r_done;
    logic [3:0]              r_class;
    logic signed [ACC_W-1:0] r_max;

    logic                    w_last;
    logic signed [7:0]       w_mul_a;
    logic signed [7:0]       w_mul_b     [0:9];
    logic signed [15:0]      w_prod      [0:9];
    logic signed [ACC_W-1:0] w_prod_ext  [0:9];
    logic [7:0]              w_bias_byte [0:9];
    logic signed [ACC_W-1:0] w_bias_ext  [0:9];
    logic signed [ACC_W-1:0] w_shift     [0:9];
    logic [7:0]              w_act       [0:9];
    logic signed [ACC_W-1:0] w_cand;
    logic                    w_gt;
    logic signed [ACC_W-1:0] w_best_nx;
    logic [3:0]              w_idx_nx;

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_out = r_class;
    assign max_logit = r_max;

    // Phase sequencing; DONE accepts a new start so back-to-back runs lose no cycle.
    always_comb begin
        w_state_nx = r_state;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE:    begin if (start) w_state_nx = S_H1_MAC; else w_state_nx = S_IDLE; end
            S_H1_MAC:  begin w_last = (r_j == 6'd61); if (w_last) w_state_nx = S_H1_ACT; else w_state_nx = S_H1_MAC; end
            S_H1_ACT:  w_state_nx = S_H2_MAC;
            S_H2_MAC:  begin w_last = (r_j == 6'd61); if (w_last) w_state_nx = S_H2_ACT; else w_state_nx = S_H2_MAC; end
            S_H2_ACT:  w_state_nx = S_OUT_MAC;
            S_OUT_MAC: begin w_last = (r_j == 6'd19); if (w_last) w_state_nx = S_ARGMAX; else w_state_nx = S_OUT_MAC; end
            S_ARGMAX:  begin w_last = (r_j == 6'd9); if (w_last) w_state_nx = S_DONE; else w_state_nx = S_ARGMAX; end
            S_DONE:    begin if (start) w_state_nx = S_H1_MAC; else w_state_nx = S_IDLE; end
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // MAC operand selection, bias reload values, ReLU/saturation and argmax compare.
    always_comb begin
        w_mul_a = 8'sd0;
        for (int n = 0; n < 10; n++) begin
            w_mul_b[n]     = 8'sd0;
            w_bias_byte[n] = 8'd0;
        end
        case (r_state)
            S_H1_MAC: begin
                w_mul_a = r_x[r_j];
                for (int n = 0; n < 10; n++) w_mul_b[n] = weight_first_h[(n*62 + int'(r_j))*8 +: 8];
            end
            S_H2_MAC: begin
                w_mul_a = r_x[r_j];
                for (int n = 0; n < 10; n++) w_mul_b[n] = weight_second_h[(n*62 + int'(r_j))*8 +: 8];
            end
            S_OUT_MAC: begin
                w_mul_a = r_h[r_j[4:0]];
                for (int n = 0; n < 10; n++) w_mul_b[n] = weight_out[(n*20 + int'(r_j))*8 +: 8];
            end
            S_IDLE, S_DONE: for (int n = 0; n < 10; n++) w_bias_byte[n] = bias_first_h[n*8 +: 8];
            S_H1_ACT:       for (int n = 0; n < 10; n++) w_bias_byte[n] = bias_second_h[n*8 +: 8];
            S_H2_ACT:       for (int n = 0; n < 10; n++) w_bias_byte[n] = bias_out[n*8 +: 8];
            default:        w_mul_a = 8'sd0;
        endcase
        for (int n = 0; n < 10; n++) begin
            w_prod[n]     = 16'(w_mul_a) * 16'(w_mul_b[n]);
            w_prod_ext[n] = {{(ACC_W-16){w_prod[n][15]}}, w_prod[n]};
            w_bias_ext[n] = {{(ACC_W-8){w_bias_byte[n][7]}}, w_bias_byte[n]} << FRAC;
            w_shift[n]    = r_acc[n] >>> FRAC;
            if (r_acc[n][ACC_W-1]) begin
                w_act[n] = 8'd0;
            end else if (|w_shift[n][ACC_W-1:7]) begin
                w_act[n] = 8'd127;
            end else begin
                w_act[n] = w_shift[n][7:0];
            end
        end
        w_cand = r_acc[r_j[3:0]];
        w_gt   = (w_cand > r_best);
        if (w_gt) begin
            w_best_nx = w_cand;
            w_idx_nx  = r_j[3:0];
        end else begin
            w_best_nx = r_best;
            w_idx_nx  = r_best_idx;
        end
    end

    // State, busy and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= (r_state == S_ARGMAX) && w_last;
        end
    end

    // Datapath: input capture, accumulators, hidden activations, argmax and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j        <= 6'd0;
            r_best     <= '0;
            r_best_idx <= 4'd0;
            r_class    <= 4'd0;
            r_max      <= '0;
            for (int j = 0; j < 62; j++) r_x[j] <= 8'sd0;
            for (int k = 0; k < 20; k++) r_h[k] <= 8'd0;
            for (int n = 0; n < 10; n++) r_acc[n] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int j = 0; j < 62; j++) r_x[j] <= x_flat[j*8 +: 8];
                        for (int n = 0; n < 10; n++) r_acc[n] <= w_bias_ext[n];
                        r_j <= 6'd0;
                    end
                end
                S_H1_MAC, S_H2_MAC, S_OUT_MAC: begin
                    for (int n = 0; n < 10; n++) r_acc[n] <= r_acc[n] + w_prod_ext[n];
                    r_j <= w_last ? 6'd0 : r_j + 6'd1;
                    if (w_last && (r_state == S_OUT_MAC)) begin
                        r_best     <= r_acc[0] + w_prod_ext[0];
                        r_best_idx <= 4'd0;
                    end
                end
                S_H1_ACT: begin
                    for (int n = 0; n < 10; n++) r_h[n] <= w_act[n];
                    for (int n = 0; n < 10; n++) r_acc[n] <= w_bias_ext[n];
                    r_j <= 6'd0;
                end
                S_H2_ACT: begin
                    for (int n = 0; n < 10; n++) r_h[10+n] <= w_act[n];
                    for (int n = 0; n < 10; n++) r_acc[n] <= w_bias_ext[n];
                    r_j <= 6'd0;
                end
                S_ARGMAX: begin
                    r_best     <= w_best_nx;
                    r_best_idx <= w_idx_nx;
                    r_j        <= r_j + 6'd1;
                    if (w_last) begin
                        r_class <= w_idx_nx;
                        r_max   <= w_best_nx;
                    end
                end
                default: r_j <= 6'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: expected class/logit pairs are queued
// at each accepted start and compared when done pulses.
module tb_nn_layer_sequencer;
    localparam int ACC_W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [495:0]      x_flat;
    logic [4959:0]     weight_first_h;
    logic [4959:0]     weight_second_h;
    logic [79:0]       bias_first_h;
    logic [79:0]       bias_second_h;
    logic [1599:0]     weight_out;
    logic [79:0]       bias_out;
    logic              busy;
    logic              done;
    logic [3:0]        class_out;
    logic [ACC_W-1:0]  max_logit;

    typedef struct { int cls; int mx; } exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   last_cls = 0;
    int   last_mx = 0;

    nn_layer_sequencer #(.FRAC(4), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_flat(x_flat),
        .weight_first_h(weight_first_h), .weight_second_h(weight_second_h),
        .bias_first_h(bias_first_h), .bias_second_h(bias_second_h),
        .weight_out(weight_out), .bias_out(bias_out),
        .busy(busy), .done(done), .class_out(class_out), .max_logit(max_logit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4959:0] fill(input logic [7:0] b);
        logic [4959:0] v;
        for (int i = 0; i < 620; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    task automatic set_all(input logic [7:0] xb, input logic [7:0] w1b, input logic [7:0] w2b,
                           input logic [7:0] b1b, input logic [7:0] b2b, input logic [7:0] wob,
                           input logic [7:0] bob);
        logic [4959:0] t;
        t = fill(xb);  x_flat = t[495:0];
        t = fill(w1b); weight_first_h = t;
        t = fill(w2b); weight_second_h = t;
        t = fill(b1b); bias_first_h = t[79:0];
        t = fill(b2b); bias_second_h = t[79:0];
        t = fill(wob); weight_out = t[1599:0];
        t = fill(bob); bias_out = t[79:0];
    endtask

    task automatic set_wo_row(input int r, input logic [7:0] b);
        for (int k = 0; k < 20; k++) weight_out[(r*20+k)*8 +: 8] = b;
    endtask

    // Accepts a start at the next rising edge (E0) and queues the expected result.
    task automatic kick(input string tag, input int cls, input int mx);
        sb.push_back('{cls, mx});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_E0"}, busy, 1);
    endtask

    // Runs from just after E0 until done; optionally pulses start at E10/E80/E156.
    task automatic wait_done(input string tag, input bit pulses);
        int   k = 0;
        bit   seen = 1'b0;
        bit   busy_ok = 1'b1;
        exp_t e;
        for (int c = 1; c <= 200 && !seen; c++) begin
            start = pulses && (c == 10 || c == 80 || c == 156);
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                k = c;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_done_edge"}, k, 156);
        chk({tag, "_busy_held"}, busy_ok, 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{-1, -1};
        chk({tag, "_class"}, class_out, e.cls);
        chk({tag, "_max_logit"}, $signed(max_logit), e.mx);
        last_cls = e.cls;
        last_mx  = e.mx;
    endtask

    // Steps through E157; with b2b set, that edge is the next inference's E0.
    task automatic finish_cycle(input string tag, input bit b2b, input int cls, input int mx);
        if (b2b) sb.push_back('{cls, mx});
        start = b2b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_low_E157"}, done, 0);
        chk({tag, "_busy_E157"}, busy, {31'd0, b2b});
        chk({tag, "_class_hold"}, class_out, last_cls);
        chk({tag, "_max_hold"}, $signed(max_logit), last_mx);
    endtask

    initial begin
        set_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_class", class_out, 0);
        chk("rst_max", $signed(max_logit), 0);
        @(negedge clk) rst_n = 1'b1;

        bias_out[3*8 +: 8] = 8'h05;
        kick("bias_only", 3, 80);
        wait_done("bias_only", 1'b0);
        finish_cycle("bias_only", 1'b0, 0, 0);

        set_all(8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set_wo_row(7, 8'h01);
        kick("ones", 7, 30);
        wait_done("ones", 1'b0);
        finish_cycle("ones", 1'b0, 0, 0);

        set_all(8'h7F, 8'h7F, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00);
        set_wo_row(2, 8'h01);
        kick("sat", 2, 1270);
        wait_done("sat", 1'b1);
        set_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
        finish_cycle("sat", 1'b1, 0, 32);
        wait_done("tie", 1'b0);
        finish_cycle("tie", 1'b0, 0, 0);

        set_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE);
        bias_out[9*8 +: 8] = 8'hFF;
        kick("neg", 9, -16);
        wait_done("neg", 1'b0);
        finish_cycle("neg", 1'b0, 0, 0);

        kick("abort", 9, -16);
        repeat (80) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_class", class_out, 0);
        chk("midrst_max", $signed(max_logit), 0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        set_all(8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        set_wo_row(7, 8'h01);
        kick("after_rst", 7, 30);
        wait_done("after_rst", 1'b0);
        finish_cycle("after_rst", 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
